spi_flash_read_seq: RTL and testbench
=====================================

Name: spi_flash_read_seq

Overview:
Sequences one SPI flash READ transaction: drives CS_n, SCLK and MOSI to send the command and a 24-bit address, then shifts in a programmed number of data bytes. Each received byte is pushed into the downstream 8-bit FIFO buffer through its write_req/full interface, and SCLK is stalled between bytes whenever the FIFO is full. The block sits between the host-side request logic and the flash pins, upstream of the FIFO.

Parameters:
CLK_DIV, 4, system_clk cycles per SCLK half-period; must be >= 2.
LEN_W, 16, width of the byte-count input.
CS_HIGH_CYC, 8, minimum system_clk cycles CS_n stays high after a transaction.

Ports:
system_clk  in  1  clock.
system_reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
start_addr  in  24  flash byte address, sampled when start is accepted.
rd_len  in  LEN_W  number of bytes to read, sampled when start is accepted.
abort  in  1  terminates the transaction at the next byte boundary.
busy  out  1  high from the cycle after start is accepted until DONE is exited.
done  out  1  one-cycle pulse when the transaction completes or is aborted.
spi_cs_n  out  1  flash chip select, active low.
spi_sclk  out  1  SPI clock, mode 0.
spi_mosi  out  1  serial data to flash.
spi_miso  in  1  serial data from flash.
fifo_write_req  out  1  one-cycle FIFO write strobe.
fifo_dataIn  out  8  byte presented to the FIFO, valid while fifo_write_req is high.
fifo_full  in  1  FIFO full flag.

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, fifo_write_req=0, fifo_dataIn=0. FSM returns to IDLE and all counters clear.
- SPI format: mode 0, MSB first, SCLK idle low. MOSI changes CLK_DIV cycles before each rising edge; MISO is sampled on each rising edge.
- One bit lasts 2*CLK_DIV cycles. A byte takes 16*CLK_DIV cycles (64 at default).
- States: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA <-> PUSH -> CS_HOLD -> DONE -> IDLE.
- IDLE: wait for start. If rd_len==0, go directly to DONE: no CS assertion and done pulses one cycle later.
- CS_SETUP: CS_n goes low and is held CLK_DIV cycles before the first SCLK edge.
- CMD: shift out 0x03.
- ADDR: shift out start_addr[23:16], then [15:8], then [7:0]. MOSI is driven 0 during DATA.
- DATA: shift in 8 bits, then go to PUSH. SCLK stays low in PUSH.
- PUSH: when fifo_full==0, assert fifo_write_req for exactly one cycle with the byte on fifo_dataIn, and decrement the remaining count.
  - While fifo_full==1, stay in PUSH with no strobe and SCLK frozen low; no data is lost.
  - After the strobe: if remaining==0 or abort is high, go to CS_HOLD; otherwise return to DATA. The next byte's first SCLK rise comes CLK_DIV cycles after the strobe.
- Abort:
  - During CMD, ADDR or DATA, the current byte finishes; a DATA byte is still pushed.
  - Then CS_HOLD.
  - In IDLE, abort has no effect.
- CS_HOLD: CS_n high and SCLK low for CS_HIGH_CYC cycles, then DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
  - start in the same cycle as done is ignored.
  - start on the following cycle is accepted.
- Remaining-byte counter is LEN_W bits and counts down; it never wraps because it is checked before decrement.
- Async reset mid-transaction: CS_n rises immediately and no FIFO write is issued.

Optional Feature:
FAST_READ_EN:
- Defined: command is 0x0B, and one dummy byte (0x00 out, input discarded) follows ADDR before DATA. This adds a DUMMY state. Required for SCLK above 50 MHz flash limits.
- Undefined: command 0x03 and no DUMMY state.

Decomposition:
Shared package spi_flash_pkg holds:
- FSM state encoding constants.
- CMD_READ=8'h03, CMD_FAST_READ=8'h0B.
- ADDR_W=24.

Sub-module spi_byte_shifter handles the SCLK divider and bit counter. It takes a load pulse and tx_byte, and returns rx_byte and byte_done. The top level owns the FSM, counters and FIFO handshake.

Test Plan:
- Basic read: start_addr=0x012345, rd_len=4, flash model returns A0..A3. MOSI shows 03 01 23 45; FIFO receives A0,A1,A2,A3; done pulses once; CS_n low for 8 bytes (512 cycles plus setup).
- Backpressure: fifo_full forced high for 200 cycles after byte 2, rd_len=5. SCLK frozen low with no strobe while full, and all 5 bytes arrive in order with no duplicates.
- Zero length: rd_len=0. CS_n never falls, no SCLK edges, done one cycle after start.
- Abort: abort pulsed mid byte 3 of rd_len=10. Exactly 3 bytes are written, then CS_n rises and done pulses.
- Reset mid-DATA: system_reset_n low during byte 1. All outputs reach reset values asynchronously, and a following start works normally.
- FAST_READ_EN build: rd_len=2. MOSI shows 0B, address, 00; the dummy byte is not written to the FIFO and 2 bytes are written.

Source files
------------

// File: rtl/spi_flash_read_seq_pkg.sv
// Shared constants for the SPI flash read sequencer: FSM state codes, flash opcodes, address width.
package spi_flash_pkg;

    localparam int unsigned ADDR_W = 24;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CS_SETUP = 4'd1;
    localparam logic [3:0] ST_CMD      = 4'd2;
    localparam logic [3:0] ST_ADDR     = 4'd3;
    localparam logic [3:0] ST_DUMMY    = 4'd4;
    localparam logic [3:0] ST_DATA     = 4'd5;
    localparam logic [3:0] ST_PUSH     = 4'd6;
    localparam logic [3:0] ST_CS_HOLD  = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

endpackage

// File: rtl/spi_flash_read_seq_if.sv
// Flash pin bundle plus downstream FIFO write port; master = sequencer, slave = flash/FIFO side.
interface spi_flash_read_seq_if;

    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       fifo_write_req;
    logic [7:0] fifo_dataIn;
    logic       fifo_full;

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, fifo_write_req, fifo_dataIn,
        input  spi_miso, fifo_full
    );

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, fifo_write_req, fifo_dataIn,
        output spi_miso, fifo_full
    );

endinterface

// File: rtl/spi_flash_read_seq_shifter.sv
// Mode-0 SPI byte engine: SCLK divider, bit counter, MSB-first TX/RX shift registers.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       system_clk,
    input  logic       system_reset_n,
    input  logic       load_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic             active_q;
    logic             sclk_q;
    logic             mosi_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_q;
    logic             div_end;

    assign div_end     = (div_q == DIV_W'(CLK_DIV - 1));
    // Asserted on the cycle whose edge drops SCLK after bit 0, so a load on that
    // same edge starts the next byte with no gap.
    assign byte_done_o = active_q & sclk_q & div_end & (bit_q == 3'd7);
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;
    assign rx_byte_o   = rx_q;

    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            div_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else if (load_i) begin
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            mosi_q   <= tx_byte_i[7];
            tx_q     <= {tx_byte_i[6:0], 1'b0};
        end else if (active_q) begin
            if (div_end) begin
                div_q <= '0;
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                    rx_q   <= {rx_q[6:0], miso_i};
                end else begin
                    sclk_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        active_q <= 1'b0;
                        mosi_q   <= 1'b0;
                    end else begin
                        bit_q  <= bit_q + 3'd1;
                        mosi_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_flash_read_seq.sv
// SPI flash READ sequencer: command, 24-bit address, N data bytes pushed to a FIFO with backpressure.
// Define FAST_READ_EN to issue 0x0B with one dummy byte instead of 0x03.
module spi_flash_read_seq
    import spi_flash_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned CS_HIGH_CYC = 8
) (
    input  logic              system_clk,
    input  logic              system_reset_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    spi_flash_read_seq_if.master bus
);

`ifdef FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = CMD_FAST_READ;
`else
    localparam logic [7:0] CMD_BYTE = CMD_READ;
`endif
    localparam int unsigned HOLD_W = $clog2(CS_HIGH_CYC + 1);

    logic [3:0]        state_q, state_d;
    logic              cs_n_q, cs_n_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        abyte_q, abyte_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              abort_q, abort_d;
    logic              wr_q, wr_d;
    logic [7:0]        data_q, data_d;

    logic       load;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       in_xfer;
    logic       abort_pend;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .system_clk     (system_clk),
        .system_reset_n (system_reset_n),
        .load_i         (load),
        .tx_byte_i      (tx_byte),
        .miso_i         (bus.spi_miso),
        .sclk_o         (bus.spi_sclk),
        .mosi_o         (bus.spi_mosi),
        .rx_byte_o      (rx_byte),
        .byte_done_o    (byte_done)
    );

    assign bus.spi_cs_n       = cs_n_q;
    assign bus.fifo_write_req = wr_q;
    assign bus.fifo_dataIn    = data_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = (state_q == ST_DONE);

    assign in_xfer    = state_q inside {ST_CS_SETUP, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_PUSH};
    assign abort_pend = abort_q | abort_i;

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        abyte_d = abyte_q;
        hold_d  = hold_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        load    = 1'b0;
        tx_byte = '0;
        abort_d = abort_q | (abort_i & in_xfer);

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    addr_d  = start_addr_i;
                    rem_d   = rd_len_i;
                    abyte_d = '0;
                    state_d = (rd_len_i == '0) ? ST_DONE : ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                // CS falls on the same edge the shifter loads, giving CLK_DIV cycles before the first rise.
                cs_n_d  = 1'b0;
                load    = 1'b1;
                tx_byte = CMD_BYTE;
                state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done) begin
                    if (abort_pend) begin
                        state_d = ST_CS_HOLD;
                        cs_n_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        load    = 1'b1;
                        tx_byte = addr_q[23:16];
                        abyte_d = 2'd1;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    if (abort_pend) begin
                        state_d = ST_CS_HOLD;
                        cs_n_d  = 1'b1;
                        hold_d  = '0;
                    end else if (abyte_q != 2'd3) begin
                        load    = 1'b1;
                        tx_byte = (abyte_q == 2'd1) ? addr_q[15:8] : addr_q[7:0];
                        abyte_d = abyte_q + 2'd1;
                    end else begin
                        load = 1'b1;
`ifdef FAST_READ_EN
                        state_d = ST_DUMMY;
`else
                        state_d = ST_DATA;
`endif
                    end
                end
            end
            ST_DUMMY: begin
                if (byte_done) begin
                    if (abort_pend) begin
                        state_d = ST_CS_HOLD;
                        cs_n_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_done) state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (!bus.fifo_full) begin
                    wr_d   = 1'b1;
                    data_d = rx_byte;
                    rem_d  = rem_q - LEN_W'(1);
                    if ((rem_q == LEN_W'(1)) || abort_pend) begin
                        state_d = ST_CS_HOLD;
                        cs_n_d  = 1'b1;
                        hold_d  = '0;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (hold_q == HOLD_W'(CS_HIGH_CYC - 1)) state_d = ST_DONE;
                else                                    hold_d  = hold_q + HOLD_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
            rem_q   <= '0;
            addr_q  <= '0;
            abyte_q <= '0;
            hold_q  <= '0;
            abort_q <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            abyte_q <= abyte_d;
            hold_q  <= hold_d;
            abort_q <= abort_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq with a bit-level flash model and FIFO write logger.
module tb_spi_flash_read_seq;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned CS_HIGH_CYC = 8;
`ifdef FAST_READ_EN
    localparam int         HDR_BITS = 40;
    localparam logic [7:0] CMD_EXP  = 8'h0B;
`else
    localparam int         HDR_BITS = 32;
    localparam logic [7:0] CMD_EXP  = 8'h03;
`endif
    localparam int HB = HDR_BITS / 8;

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          abort_rise;
        int          stall_after;
        int          stall_cyc;
        int          exp_wr;
        int          exp_mosi;
        int          exp_cs_low;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             done;

    spi_flash_read_seq_if bus();

    spi_flash_read_seq #(
        .CLK_DIV     (CLK_DIV),
        .LEN_W       (LEN_W),
        .CS_HIGH_CYC (CS_HIGH_CYC)
    ) dut (
        .system_clk     (clk),
        .system_reset_n (rst_n),
        .start_i        (start),
        .start_addr_i   (addr),
        .rd_len_i       (len),
        .abort_i        (abort),
        .busy_o         (busy),
        .done_o         (done),
        .bus            (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;
    int         rise_cnt  = 0;
    int         sclk_rises = 0;
    int         rises_cs_high = 0;
    int         cs_low = 0;
    int         done_cnt = 0;
    int         csrise_cyc = 0;
    int         done_cyc = 0;
    logic [7:0] mosi_sh = '0;
    logic [7:0] mosi_log[$];
    logic [7:0] wr_log[$];
    vec_t       vecs[6];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] mosi_exp(input logic [23:0] a, input int i);
        case (i)
            0:       return CMD_EXP;
            1:       return a[23:16];
            2:       return a[15:8];
            3:       return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Flash model and FIFO logger, evaluated once per clock on the falling edge.
    task automatic mon();
        int         idx;
        logic [7:0] b;
        if (prev_cs && !bus.spi_cs_n) rise_cnt = 0;
        if (!prev_cs && bus.spi_cs_n) csrise_cyc = cyc;
        if (!prev_sclk && bus.spi_sclk) begin
            sclk_rises++;
            if (bus.spi_cs_n) rises_cs_high++;
            mosi_sh = {mosi_sh[6:0], bus.spi_mosi};
            rise_cnt++;
            if (rise_cnt % 8 == 0) mosi_log.push_back(mosi_sh);
        end
        if (prev_sclk && !bus.spi_sclk && rise_cnt >= HDR_BITS) begin
            idx = rise_cnt - HDR_BITS;
            b = 8'hA0 + 8'(idx / 8);
            bus.spi_miso = b[7 - (idx % 8)];
        end
        if (bus.fifo_write_req) wr_log.push_back(bus.fifo_dataIn);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!bus.spi_cs_n) cs_low++;
        prev_sclk = bus.spi_sclk;
        prev_cs   = bus.spi_cs_n;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic clear_logs();
        mosi_log.delete();
        wr_log.delete();
        sclk_rises = 0;
        rises_cs_high = 0;
        cs_low = 0;
        done_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int t;
        int r0;
        int w0;
        int stall_left;
        bit stalled;
        bit ab_done;
        t = 0; r0 = 0; w0 = 0; stall_left = 0; stalled = 0; ab_done = 0;
        clear_logs();
        addr  = v.addr;
        len   = LEN_W'(v.len);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && t < 4000) begin
            tick();
            t++;
            if (abort) abort = 1'b0;
            if (v.abort_rise > 0 && !ab_done && rise_cnt == v.abort_rise) begin
                abort   = 1'b1;
                ab_done = 1'b1;
            end
            if (v.stall_after > 0 && !stalled && wr_log.size() == v.stall_after) begin
                bus.fifo_full = 1'b1;
                stalled    = 1'b1;
                stall_left = v.stall_cyc;
                r0 = sclk_rises;
                w0 = wr_log.size();
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    chk($sformatf("v%0d_stall_rises", vi), sclk_rises - r0, 8);
                    chk($sformatf("v%0d_stall_writes", vi), wr_log.size() - w0, 0);
                    chk($sformatf("v%0d_stall_sclk_low", vi), int'(bus.spi_sclk), 0);
                    bus.fifo_full = 1'b0;
                end
            end
        end
        abort = 1'b0;
        chk($sformatf("v%0d_done_seen", vi), done_cnt, 1);
        chk($sformatf("v%0d_done_after_cs", vi), done_cyc - csrise_cyc, CS_HIGH_CYC);
        tick();
        tick();
        chk($sformatf("v%0d_done_once", vi), done_cnt, 1);
        chk($sformatf("v%0d_idle_busy", vi), int'(busy), 0);
        chk($sformatf("v%0d_idle_cs", vi), int'(bus.spi_cs_n), 1);
        chk($sformatf("v%0d_sclk_cs_high", vi), rises_cs_high, 0);
        chk($sformatf("v%0d_writes", vi), wr_log.size(), v.exp_wr);
        for (int i = 0; i < wr_log.size() && i < v.exp_wr; i++)
            chk($sformatf("v%0d_byte%0d", vi, i), int'(wr_log[i]), int'(8'hA0 + 8'(i)));
        chk($sformatf("v%0d_mosi_count", vi), mosi_log.size(), v.exp_mosi);
        for (int i = 0; i < mosi_log.size() && i < v.exp_mosi; i++)
            chk($sformatf("v%0d_mosi%0d", vi, i), int'(mosi_log[i]), int'(mosi_exp(v.addr, i)));
        if (v.exp_cs_low >= 0)
            chk($sformatf("v%0d_cs_low_cyc", vi), cs_low, v.exp_cs_low);
    endtask

    initial begin
        int t;
        vecs[0] = '{24'h012345, 4,  0,             0, 0,   4, HB + 4, 16 * CLK_DIV * (HB + 4) + 4};
        vecs[1] = '{24'hABCDEF, 5,  0,             2, 200, 5, HB + 5, -1};
        vecs[2] = '{24'h000001, 10, HDR_BITS + 20, 0, 0,   3, HB + 3, -1};
        vecs[3] = '{24'hFFFFFF, 1,  0,             0, 0,   1, HB + 1, 16 * CLK_DIV * (HB + 1) + 1};
        vecs[4] = '{24'h800000, 3,  4,             0, 0,   0, 1,      -1};
        vecs[5] = '{24'h5A5A5A, 2,  0,             0, 0,   2, HB + 2, -1};

        rst_n = 1'b0; start = 1'b0; addr = '0; len = '0; abort = 1'b0;
        bus.spi_miso = 1'b0;
        bus.fifo_full = 1'b0;
        tick();
        tick();
        chk("rst_cs_n", int'(bus.spi_cs_n), 1);
        chk("rst_sclk", int'(bus.spi_sclk), 0);
        chk("rst_mosi", int'(bus.spi_mosi), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr", int'(bus.fifo_write_req), 0);
        chk("rst_data", int'(bus.fifo_dataIn), 0);
        rst_n = 1'b1;
        tick();

        // Abort while idle must not disturb the next transaction.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Zero length, plus start ignored during done and accepted right after.
        clear_logs();
        addr = 24'h111111; len = '0; start = 1'b1;
        tick();
        chk("zl_done", int'(done), 1);
        chk("zl_busy", int'(busy), 1);
        tick();
        chk("zl_start_in_done_ignored", int'(done | busy), 0);
        tick();
        start = 1'b0;
        chk("zl_restart_done", int'(done), 1);
        tick();
        chk("zl_done_drop", int'(done), 0);
        chk("zl_cs_low", cs_low, 0);
        chk("zl_sclk_rises", sclk_rises, 0);

        // Asynchronous reset during the first data byte.
        clear_logs();
        addr = 24'h000100; len = LEN_W'(4); start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (rise_cnt != HDR_BITS + 3 && t < 2000) begin
            tick();
            t++;
        end
        chk("rr_reached_data", rise_cnt, HDR_BITS + 3);
        chk("rr_cs_low_before", int'(bus.spi_cs_n), 0);
        rst_n = 1'b0;
        #1;
        chk("rr_cs_n", int'(bus.spi_cs_n), 1);
        chk("rr_sclk", int'(bus.spi_sclk), 0);
        chk("rr_busy", int'(busy), 0);
        chk("rr_wr", int'(bus.fifo_write_req), 0);
        chk("rr_data", int'(bus.fifo_dataIn), 0);
        tick();
        tick();
        chk("rr_no_writes", wr_log.size(), 0);
        rst_n = 1'b1;
        tick();
        run_vec(vecs[5], 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
